// File: rtl/fsm_counter_launcher.sv
// Batch launcher for one counter worker: runs up to 15 jobs, count = base + k*step (mod 128).
// Latency: start->o_run in 2 cycles with the worker idle, worker done->next WAIT_IDLE or DONE in 1 cycle.
// Backpressure: waits on worker idle/done levels; a per-job watchdog aborts the batch with o_err after TIMEOUT cycles.
module fsm_counter_launcher #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [3:0] i_num_jobs,
  input  logic [6:0] i_base_cnt,
  input  logic [6:0] i_step,
  input  logic       i_worker_idle,
  input  logic       i_worker_done,
  output logic       o_run,
  output logic [6:0] o_num_cnt,
  output logic       o_idle,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_jobs_done
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t          state;
  logic [3:0]      num_jobs;
  logic [3:0]      job_idx;
  logic [6:0]      step;
  logic [WD_W-1:0] wd_cnt;

  logic last_job;
  logic job_end;
  logic launch_go;
  logic wd_expired;

  // A zero count is a skipped job; worker done only counts while waiting for it.
  assign last_job   = (job_idx == num_jobs - 4'd1);
  assign job_end    = ((state == S_WAIT_IDLE) && (o_num_cnt == 7'd0)) ||
                      ((state == S_WAIT_DONE) && i_worker_done);
  assign launch_go  = (state == S_WAIT_IDLE) && (o_num_cnt != 7'd0) && i_worker_idle;
  assign wd_expired = (wd_cnt == WD_LAST);

  // Batch sequencer: state, latched batch parameters, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      num_jobs    <= 4'd0;
      job_idx     <= 4'd0;
      step        <= 7'd0;
      wd_cnt      <= '0;
      o_run       <= 1'b0;
      o_num_cnt   <= 7'd0;
      o_idle      <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_jobs_done <= 4'd0;
    end else begin
      // Pulse outputs: each lives for exactly one cycle of LAUNCH or DONE.
      o_run  <= 1'b0;
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            num_jobs    <= i_num_jobs;
            step        <= i_step;
            o_num_cnt   <= i_base_cnt;
            o_jobs_done <= 4'd0;
            job_idx     <= 4'd0;
            o_err       <= 1'b0;
            wd_cnt      <= '0;
            o_idle      <= 1'b0;
            if (i_num_jobs == 4'd0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= S_WAIT_IDLE;
              o_busy <= 1'b1;
            end
          end
        end

        S_WAIT_IDLE, S_WAIT_DONE: begin
          if (job_end) begin
            o_jobs_done <= o_jobs_done + 4'd1;
            if (last_job) begin
              state  <= S_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              // Next count is ready well before the following o_run.
              job_idx   <= job_idx + 4'd1;
              o_num_cnt <= o_num_cnt + step;
              wd_cnt    <= '0;
              state     <= S_WAIT_IDLE;
            end
          end else if (launch_go) begin
            state <= S_LAUNCH;
            o_run <= 1'b1;
          end else if (wd_expired) begin
            // Hung worker: abort the batch, the current job is not counted.
            o_err  <= 1'b1;
            state  <= S_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_LAUNCH: begin
          // Worker done is ignored here, so a stale done level cannot end the new job.
          state  <= S_WAIT_DONE;
          wd_cnt <= '0;
        end

        S_DONE: begin
          state  <= S_IDLE;
          o_idle <= 1'b1;
        end

        default: begin
          state  <= S_IDLE;
          o_idle <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_counter_launcher.sv
// Bench for fsm_counter_launcher: table of batches plus hand sequences for timing and reset corners.
// A behavioural counter worker answers o_run; expected counts are queued per batch and popped on o_run.
// Worker can be told to hang so the watchdog path is exercised.
module tb_fsm_counter_launcher;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [3:0] i_num_jobs;
  logic [6:0] i_base_cnt;
  logic [6:0] i_step;
  logic       w_idle;
  logic       w_done;
  logic       o_run;
  logic [6:0] o_num_cnt;
  logic       o_idle;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [3:0] o_jobs_done;

  fsm_counter_launcher #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_num_jobs   (i_num_jobs),
    .i_base_cnt   (i_base_cnt),
    .i_step       (i_step),
    .i_worker_idle(w_idle),
    .i_worker_done(w_done),
    .o_run        (o_run),
    .o_num_cnt    (o_num_cnt),
    .o_idle       (o_idle),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_jobs_done  (o_jobs_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Worker model: busy for w_lat cycles after o_run, then done+idle held until next run.
  logic w_rst;
  int   w_lat;
  bit   w_hang;
  int   w_cnt;
  always @(posedge clk) begin
    if (w_rst) begin
      w_idle <= 1'b1;
      w_done <= 1'b0;
      w_cnt  <= 0;
    end else if (o_run) begin
      w_idle <= 1'b0;
      w_done <= 1'b0;
      w_cnt  <= w_lat;
    end else if (!w_idle && !w_hang) begin
      if (w_cnt <= 1) begin
        w_done <= 1'b1;
        w_idle <= 1'b1;
      end else begin
        w_cnt <= w_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 0;
  int run_count = 0;
  int run_cyc   = 0;
  int done_cyc  = 0;
  int wdone_cyc = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: one-hot status every cycle, scoreboard pop on each o_run, event timestamps.
  initial begin
    logic prev_wd;
    prev_wd = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("status_onehot", $countones({o_idle, o_busy, o_done}), 1);
        if (w_done && !prev_wd) wdone_cyc = cyc;
        if (o_run) begin
          run_cyc = cyc;
          run_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_run: got o_run with count %0d, required no launch", o_num_cnt);
          end else begin
            check("run_count_value", int'(o_num_cnt), int'(exp_q.pop_front()));
          end
        end
        if (o_done) done_cyc = cyc;
      end
      prev_wd = w_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  task automatic worker_reset(input int lat, input bit hang);
    @(posedge clk);
    #1;
    w_rst  = 1'b1;
    w_lat  = lat;
    w_hang = hang;
    @(posedge clk);
    #1;
    w_rst = 1'b0;
  endtask

  task automatic load_exp(input logic [3:0] jobs, input logic [6:0] base, input logic [6:0] stp,
                          input bit hang);
    exp_q.delete();
    for (int k = 0; k < int'(jobs); k++) begin
      int c;
      c = (int'(base) + k * int'(stp)) % 128;
      if (c != 0) begin
        exp_q.push_back(7'(c));
        if (hang) break;
      end
    end
  endtask

  // Returns just after the edge that accepts the start; parameters then change to junk.
  task automatic start_batch(input logic [3:0] jobs, input logic [6:0] base, input logic [6:0] stp);
    @(posedge clk);
    #1;
    i_start    = 1'b1;
    i_num_jobs = jobs;
    i_base_cnt = base;
    i_step     = stp;
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    i_num_jobs = 4'($urandom);
    i_base_cnt = 7'($urandom);
    i_step     = 7'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no o_done within %0d cycles, required a done pulse", budget);
    end
    #1;
  endtask

  typedef struct {
    logic [3:0] jobs;
    logic [6:0] base;
    logic [6:0] step;
    int         lat;
    bit         hang;
    int         exp_runs;
    int         exp_jd;
    int         exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit got;

    vecs[0] = '{4'd1,  7'd100, 7'd0,   5, 1'b0, 1,  1,  0};  // single job
    vecs[1] = '{4'd4,  7'd10,  7'd5,   3, 1'b0, 4,  4,  0};  // batch 10,15,20,25
    vecs[2] = '{4'd4,  7'd120, 7'd4,   2, 1'b0, 3,  4,  0};  // wrap, count 0 skipped
    vecs[3] = '{4'd1,  7'd50,  7'd0,   1, 1'b1, 1,  0,  1};  // hung worker
    vecs[4] = '{4'd2,  7'd7,   7'd9,   1, 1'b0, 2,  2,  0};  // good worker clears err
    vecs[5] = '{4'd0,  7'd33,  7'd1,   1, 1'b0, 0,  0,  0};  // empty batch
    vecs[6] = '{4'd15, 7'd1,   7'd127, 1, 1'b0, 14, 15, 0};  // max jobs, one skip
    vecs[7] = '{4'd3,  7'd0,   7'd0,   1, 1'b0, 0,  3,  0};  // all skipped

    reset      = 1'b1;
    i_start    = 1'b0;
    i_num_jobs = 4'd0;
    i_base_cnt = 7'd0;
    i_step     = 7'd0;
    w_rst      = 1'b1;
    w_lat      = 1;
    w_hang     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", o_idle, 1);
    check("reset_busy", o_busy, 0);
    check("reset_run", o_run, 0);
    check("reset_done", o_done, 0);
    check("reset_err", o_err, 0);
    check("reset_num_cnt", o_num_cnt, 0);
    check("reset_jobs_done", o_jobs_done, 0);
    reset  = 1'b0;
    w_rst  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      worker_reset(vecs[i].lat, vecs[i].hang);
      load_exp(vecs[i].jobs, vecs[i].base, vecs[i].step, vecs[i].hang);
      run_count = 0;
      start_batch(vecs[i].jobs, vecs[i].base, vecs[i].step);
      wait_done(600, got);
      if (got) begin
        check($sformatf("row%0d_jobs_done", i), o_jobs_done, vecs[i].exp_jd);
        check($sformatf("row%0d_err", i), o_err, vecs[i].exp_err);
        check($sformatf("row%0d_runs", i), run_count, vecs[i].exp_runs);
        check($sformatf("row%0d_queue_left", i), exp_q.size(), 0);
        if (vecs[i].hang)
          check($sformatf("row%0d_timeout_cycles", i), done_cyc - run_cyc, TMO + 1);
        else if (vecs[i].exp_runs > 0)
          check($sformatf("row%0d_done_latency", i), done_cyc - wdone_cyc, 1);
        @(negedge clk);
        check($sformatf("row%0d_back_idle", i), o_idle, 1);
        check($sformatf("row%0d_err_sticky", i), o_err, vecs[i].exp_err);
      end
      exp_q.delete();
    end

    // Launch timing and start ignored while busy.
    worker_reset(4, 1'b0);
    load_exp(4'd3, 7'd40, 7'd3, 1'b0);
    run_count = 0;
    start_batch(4'd3, 7'd40, 7'd3);
    @(negedge clk);
    check("t1_wait_idle_busy", o_busy, 1);
    check("t1_no_run_yet", o_run, 0);
    @(negedge clk);
    check("t2_launch_run", o_run, 1);
    @(posedge clk);
    #1;
    i_start    = 1'b1;
    i_num_jobs = 4'd1;
    i_base_cnt = 7'd99;
    i_step     = 7'd1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_done(600, got);
    if (got) begin
      check("busy_start_jobs_done", o_jobs_done, 3);
      check("busy_start_runs", run_count, 3);
      check("busy_start_queue_left", exp_q.size(), 0);
    end
    exp_q.delete();

    // Empty batch: done right after the start edge.
    worker_reset(1, 1'b0);
    run_count = 0;
    start_batch(4'd0, 7'd5, 7'd5);
    @(negedge clk);
    check("zero_jobs_done_pulse", o_done, 1);
    check("zero_jobs_count", o_jobs_done, 0);
    @(negedge clk);
    check("zero_jobs_idle", o_idle, 1);
    check("zero_jobs_runs", run_count, 0);

    // Reset while waiting on a hung worker.
    worker_reset(1, 1'b1);
    load_exp(4'd2, 7'd30, 7'd1, 1'b1);
    start_batch(4'd2, 7'd30, 7'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_run) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_mid_launch_seen", got, 1);
    @(negedge clk);
    check("rst_mid_in_wait_done", o_busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_idle", o_idle, 1);
    check("rst_mid_run", o_run, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_done", o_done, 0);
    check("rst_mid_err", o_err, 0);
    check("rst_mid_num_cnt", o_num_cnt, 0);
    check("rst_mid_jobs_done", o_jobs_done, 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_counter_launcher.md
# fsm_counter_launcher

Initiator side of the run/done counter handshake: it drives `o_run`/`o_num_cnt` into a counter worker and consumes the worker's `idle`/`done` status. On one `i_start` pulse it launches a batch of up to 15 jobs back-to-back. Job k runs with count `base + k*step`, modulo 128. It includes a per-job watchdog so a hung worker cannot stall the controller. It sits between a host or test sequencer and one counter worker instance.

## Interface
- `TIMEOUT`, default 1024: max cycles spent in WAIT_IDLE or WAIT_DONE per job before abort; minimum 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. Sampled on `clk` rising edge.
- `i_start`  in  1  one-cycle batch request. Honoured only in IDLE.
- `i_num_jobs`  in  4  number of jobs, 0..15. Latched at start.
- `i_base_cnt`  in  7  count for job 0. Latched at start.
- `i_step`  in  7  count increment per job. Latched at start.
- `i_worker_idle`  in  1  worker idle status (level).
- `i_worker_done`  in  1  worker done status (level).
- `o_run`  out  1  one-cycle launch pulse to the worker.
- `o_num_cnt`  out  7  count for the current job. Stable from LAUNCH until the job ends.
- `o_idle`  out  1  high in IDLE.
- `o_busy`  out  1  high in WAIT_IDLE, LAUNCH and WAIT_DONE.
- `o_done`  out  1  one-cycle pulse when a batch ends, normally or by abort.
- `o_err`  out  1  sticky timeout flag. Cleared by the next accepted start or by reset.
- `o_jobs_done`  out  4  jobs completed in the current or last batch.

## Operation
- States: IDLE, WAIT_IDLE, LAUNCH, WAIT_DONE, DONE. State is held in a register; all outputs are decoded from registers.
- IDLE with `i_start`=1:
  - latch `i_num_jobs`, `i_base_cnt`, `i_step`;
  - set `o_num_cnt`=base, clear `o_jobs_done`, job index and `o_err`;
  - next state is WAIT_IDLE, or DONE if `i_num_jobs`=0.
- WAIT_IDLE:
  - if the current count is 0, the job is skipped: treat it as completed without launching;
  - otherwise go to LAUNCH on `i_worker_idle`=1.
- LAUNCH: `o_run`=1 for exactly this cycle. Next state is always WAIT_DONE.
- WAIT_DONE: `i_worker_done`=1 completes the job. `o_jobs_done` increments.
- Job completion, whether skipped or done:
  - if this was the last job (index = num_jobs-1), go to DONE;
  - otherwise increment the index, set `o_num_cnt` += step (7-bit wrap, carry discarded), and go to WAIT_IDLE.
- Watchdog: a cycle counter clears on entry to WAIT_IDLE or WAIT_DONE and increments each cycle in those states. When it reaches TIMEOUT-1 with no progress, set `o_err`=1 and go to DONE. The timed-out job is not counted.
- DONE: `o_done`=1 for one cycle, then IDLE.
- `i_start` in any state other than IDLE is ignored. Latched parameters do not change mid-batch.
- `i_worker_done` is sampled only in WAIT_DONE. A done level left over from the previous job cannot complete the next one, because WAIT_IDLE and LAUNCH come in between.

## Timing
- Reset values: state IDLE, `o_idle`=1. `o_run`, `o_busy`, `o_done`, `o_err` are 0; `o_num_cnt` and `o_jobs_done` are 0.
- Reset mid-batch: on the next edge, `o_run` is 0 and the state is IDLE. The worker is not reset by this block.
- With the worker already idle and i_start accepted at edge T: WAIT_IDLE from T+1, LAUNCH (`o_run`=1) in cycle T+2, WAIT_DONE from T+3.
- Worker done seen at edge D:
  - next job's WAIT_IDLE from D+1;
  - for the last job, DONE with `o_done`=1 from D+1 and IDLE from D+2.
- Minimum launch-to-launch spacing is 3 cycles.
- Skipped job: 1 cycle in WAIT_IDLE, with no `o_run`.
- `i_num_jobs`=0: DONE in the cycle after the start edge, `o_jobs_done`=0, no `o_run`.
- `o_num_cnt` updates on the same edge that leaves WAIT_DONE, so it is valid at least one cycle before the next `o_run`.
- `o_idle`, `o_busy` and `o_done` are mutually exclusive, and exactly one is high in every cycle.

## Test plan
- Single job: base=100, step=0, jobs=1, with a real counter worker.
  - Required: one `o_run` pulse with `o_num_cnt`=100;
  - `o_done` 1 cycle after worker done;
  - `o_jobs_done`=1, `o_err`=0.
- Batch: base=10, step=5, jobs=4.
  - Required: `o_run` exactly 4 times, with counts 10, 15, 20, 25;
  - `o_jobs_done`=4, one `o_done` pulse.
- Wrap and skip: base=120, step=4, jobs=4.
  - Counts are 120, 124, 0, 4. The count-0 job is skipped with no `o_run`.
  - Required: 3 launches, `o_jobs_done`=4.
- Timeout: TIMEOUT=16, worker model never asserts done.
  - Required: `o_err`=1 and `o_done` pulse 16 cycles after entering WAIT_DONE, `o_jobs_done`=0.
  - A following start with a good worker clears `o_err`.
- Edge cases:
  - jobs=0 gives `o_done` one cycle after start with no `o_run`;
  - `i_start` while busy is ignored, so the counts of the running batch are unchanged;
  - `reset` asserted during WAIT_DONE gives `o_idle`=1 and all other outputs 0 on the next edge.
